trng_packetizer: RTL and testbench

- Upstream feeder for packet_com.
- Collects raw entropy bits from the TRNG core and packs them LSB-first into bytes.
- Buffers the bytes in a small FIFO and emits fixed-size framed packets: sequence byte, payload, XOR checksum.
- Drives packet_com's start/size/write/ready interface directly.

---
 rtl/trng_packetizer.sv | 199 +++++++++++++++++++
 tb/tb_trng_packetizer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_packetizer.sv
// trng_packetizer: packs raw TRNG bits LSB-first into bytes, buffers them in a byte FIFO and
// emits framed packets [seq][payload x PAYLOAD_BYTES][xor checksum] to a packet_com block.
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_enable, i_bit,    entropy bit input; a bit is taken when i_enable & i_bit_valid
//   i_bit_valid
//   i_ready             packet_com ready (a write may fire in a cycle where this is high)
//   i_packet_ongoing    packet_com busy flag
//   o_start_packet      one-cycle packet start pulse
//   o_packet_size       constant PAYLOAD_BYTES+2
//   o_dat, o_write      byte and its one-cycle write strobe
//   o_fifo_level        bytes buffered
//   o_overflow          sticky: a completed byte was dropped on a full FIFO
//   o_seq               sequence number of the next packet
module trng_packetizer #(
  parameter int unsigned PAYLOAD_BYTES = 16,
  parameter int unsigned FIFO_DEPTH    = 32,
  parameter int unsigned FIFO_AW       = 5
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_bit,
  input  logic             i_bit_valid,
  input  logic             i_ready,
  input  logic             i_packet_ongoing,
  output logic             o_start_packet,
  output logic [6:0]       o_packet_size,
  output logic [7:0]       o_dat,
  output logic             o_write,
  output logic [FIFO_AW:0] o_fifo_level,
  output logic             o_overflow,
  output logic [7:0]       o_seq
);

  typedef enum logic [2:0] {
    StIdle, StStart, StGuard, StSeq, StPayload, StCsum, StWaitEnd
  } state_e;

  localparam logic [FIFO_AW:0]   LevelFull = (FIFO_AW + 1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW:0]   LevelPkt  = (FIFO_AW + 1)'(PAYLOAD_BYTES);
  localparam logic [FIFO_AW:0]   LevelOne  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PtrOne    = FIFO_AW'(1);
  localparam logic [6:0]         LastIdx   = 7'(PAYLOAD_BYTES - 1);

  assign o_packet_size = 7'(PAYLOAD_BYTES + 2);

  // Bit packer
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] part_q, part_d;
  logic       push_req;
  logic [7:0] push_byte;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    part_d    = part_q;
    push_req  = 1'b0;
    // The 8th bit goes straight into the pushed byte, never into part_q.
    push_byte = {i_bit, part_q};
    if (i_enable && i_bit_valid) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        push_req = 1'b1;
        part_d   = '0;
      end else begin
        part_d[bit_cnt_q] = i_bit;
      end
    end
  end

  // Byte FIFO
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   level_q, level_d;
  logic               pop, push_ok, ovf_q;
  logic [7:0]         head;

  assign head = mem_q[rd_ptr_q];
  // A push on a full FIFO still fits if a pop leaves this cycle.
  assign push_ok = push_req && ((level_q != LevelFull) || pop);

  always_comb begin
    level_d = level_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LevelOne;
      2'b01:   level_d = level_q - LevelOne;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_byte;
  end

  // Packet FSM
  state_e     state_q, state_d;
  logic       write_q, write_d, start_q, start_d, fire;
  logic [7:0] dat_q, dat_d, seq_q, seq_d, csum_q, csum_d;
  logic [6:0] cnt_q, cnt_d;

  // write_q blocks back-to-back strobes, giving at most one write every two cycles.
  assign fire = i_ready && !write_q;

  always_comb begin
    state_d = state_q;
    write_d = 1'b0;
    start_d = 1'b0;
    dat_d   = dat_q;
    seq_d   = seq_q;
    csum_d  = csum_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if ((level_q >= LevelPkt) && !i_packet_ongoing) begin
          state_d = StStart;
          start_d = 1'b1;
        end
      end
      StStart: begin
        csum_d  = '0;
        cnt_d   = '0;
        state_d = StGuard;
      end
      StGuard: state_d = StSeq;
      StSeq: begin
        if (fire) begin
          write_d = 1'b1;
          dat_d   = seq_q;
          csum_d  = csum_q ^ seq_q;
          state_d = StPayload;
        end
      end
      StPayload: begin
        if (fire) begin
          write_d = 1'b1;
          dat_d   = head;
          csum_d  = csum_q ^ head;
          pop     = 1'b1;
          cnt_d   = cnt_q + 7'd1;
          if (cnt_q == LastIdx) state_d = StCsum;
        end
      end
      StCsum: begin
        if (fire) begin
          write_d = 1'b1;
          dat_d   = csum_q;
          seq_d   = seq_q + 8'd1;
          state_d = StWaitEnd;
        end
      end
      StWaitEnd: begin
        if (!i_packet_ongoing && !write_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bit_cnt_q <= '0;
      part_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
      state_q   <= StIdle;
      write_q   <= 1'b0;
      start_q   <= 1'b0;
      dat_q     <= '0;
      seq_q     <= '0;
      csum_q    <= '0;
      cnt_q     <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      part_q    <= part_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)     rd_ptr_q <= rd_ptr_q + PtrOne;
      level_q   <= level_d;
      ovf_q     <= ovf_q | (push_req & ~push_ok);
      state_q   <= state_d;
      write_q   <= write_d;
      start_q   <= start_d;
      dat_q     <= dat_d;
      seq_q     <= seq_d;
      csum_q    <= csum_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_start_packet = start_q;
  assign o_write        = write_q;
  assign o_dat          = dat_q;
  assign o_fifo_level   = level_q;
  assign o_overflow     = ovf_q;
  assign o_seq          = seq_q;

endmodule

// File: tb/tb_trng_packetizer.sv
// tb_trng_packetizer: self-checking bench for trng_packetizer. A queue-based reference model
// tracks the bytes formed from the bits driven in, and a packet_com stand-in checks every
// framed packet (seq, payload order, xor checksum), write spacing, level and overflow.
module tb_trng_packetizer;

  localparam int PB    = 16;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          clk;
  logic          i_reset, i_enable, i_bit, i_bit_valid, i_ready, i_packet_ongoing;
  logic          o_start_packet, o_write, o_overflow;
  logic [6:0]    o_packet_size;
  logic [7:0]    o_dat, o_seq;
  logic [AW:0]   o_fifo_level;

  trng_packetizer #(
    .PAYLOAD_BYTES(PB),
    .FIFO_DEPTH   (DEPTH),
    .FIFO_AW      (AW)
  ) dut (
    .i_clk           (clk),
    .i_reset         (i_reset),
    .i_enable        (i_enable),
    .i_bit           (i_bit),
    .i_bit_valid     (i_bit_valid),
    .i_ready         (i_ready),
    .i_packet_ongoing(i_packet_ongoing),
    .o_start_packet  (o_start_packet),
    .o_packet_size   (o_packet_size),
    .o_dat           (o_dat),
    .o_write         (o_write),
    .o_fifo_level    (o_fifo_level),
    .o_overflow      (o_overflow),
    .o_seq           (o_seq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] mq[$];
  logic [7:0] m_part;
  int         m_nbits;
  logic       m_ovf;
  logic [7:0] seq_m, csum_m;
  logic       pkt_active, ongoing_m;
  int         rx_idx, pkt_count, n_starts;
  logic [7:0] last_pkt [PB+2];
  logic [7:0] last_seq;
  logic       last_seq_valid, wrap_seen;

  // Bench controls
  int   bit_mode;    // 0: main drives bits, 1: random bits
  int   ready_mode;  // 0: low, 1: high, 2: random
  logic force_ongoing, pack_en, chk_level;
  logic prev_write, prev_start, ready_at_edge;

  typedef struct {
    logic [7:0] seq_bits;  // bit 7 is the first bit in time
    int         gap;       // enable-low bits inserted after the 3rd bit
    logic [7:0] exp_byte;
    int         exp_level;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    m_part = '0; m_nbits = 0; m_ovf = 1'b0;
    seq_m = '0; csum_m = '0;
    pkt_active = 1'b0; ongoing_m = 1'b0; rx_idx = 0;
  endtask

  task automatic model_take(input logic b);
    m_part[m_nbits] = b;
    m_nbits++;
    if (m_nbits == 8) begin
      if (mq.size() < DEPTH) mq.push_back(m_part);
      else m_ovf = 1'b1;
      m_nbits = 0;
      m_part  = '0;
    end
  endtask

  task automatic observe();
    logic [7:0] exp;
    if (o_start_packet) begin
      check("pkt_size", 32'(o_packet_size), 32'(PB + 2));
      check("start_in_pkt", 32'(pkt_active), 32'd0);
      check("start_level_ok", 32'(mq.size() >= PB), 32'd1);
      check("start_width", 32'(prev_start), 32'd0);
      pkt_active = 1'b1; rx_idx = 0; csum_m = '0; ongoing_m = 1'b1; n_starts++;
    end
    if (o_write) begin
      check("wr_needs_ready", 32'(ready_at_edge), 32'd1);
      check("wr_spacing", 32'(prev_write), 32'd0);
      if (!pkt_active) begin
        fail_now("wr_outside_pkt");
      end else begin
        if (rx_idx == 0) exp = seq_m;
        else if (rx_idx <= PB) begin
          if (mq.size() == 0) begin
            fail_now("payload_empty");
            exp = 8'h00;
          end else exp = mq.pop_front();
        end else exp = csum_m;
        check("wr_dat", 32'(o_dat), 32'(exp));
        csum_m ^= exp;
        last_pkt[rx_idx] = o_dat;
        if (rx_idx == 0) begin
          if (last_seq_valid && last_seq == 8'hFF && o_dat == 8'h00) wrap_seen = 1'b1;
          last_seq = o_dat; last_seq_valid = 1'b1;
        end
        rx_idx++;
        if (rx_idx == PB + 2) begin
          pkt_active = 1'b0; ongoing_m = 1'b0; seq_m++; pkt_count++;
        end
      end
    end
  endtask

  task automatic tick();
    logic take, rst, b;
    if (bit_mode == 1) begin
      i_enable    = ($urandom_range(0, 9) != 0);
      i_bit_valid = ($urandom_range(0, 7) != 0);
      i_bit       = 1'($urandom_range(0, 1));
    end
    i_ready = (ready_mode == 1) ? 1'b1 :
              (ready_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b0;
    i_packet_ongoing = ongoing_m | force_ongoing;
    take = i_enable & i_bit_valid;
    rst  = i_reset;
    b    = i_bit;
    ready_at_edge = i_ready;
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else begin
      observe();
      if (take && pack_en) model_take(b);
    end
    if (chk_level) check("level", 32'(o_fifo_level), 32'(mq.size()));
    check("overflow", 32'(o_overflow), 32'(m_ovf));
    check("seq", 32'(o_seq), 32'(seq_m));
    prev_write = o_write;
    prev_start = o_start_packet;
  endtask

  task automatic feed_bit(input logic b, input logic en);
    i_bit = b; i_bit_valid = 1'b1; i_enable = en;
    tick();
    i_bit_valid = 1'b0; i_enable = 1'b1;
  endtask

  task automatic feed_byte(input logic [7:0] v);
    for (int k = 0; k < 8; k++) feed_bit(v[k], 1'b1);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
  endtask

  task automatic wait_pkts(input int target, input int budget);
    int n = 0;
    while (pkt_count < target && n < budget) begin
      tick();
      n++;
    end
    check("pkt_done", 32'(pkt_count), 32'(target));
  endtask

  task automatic wait_idx(input int target, input int budget);
    int n = 0;
    while (!(pkt_active && rx_idx >= target) && n < budget) begin
      tick();
      n++;
    end
    check("idx_reached", 32'(pkt_active && rx_idx >= target), 32'd1);
  endtask

  initial begin
    int starts0, writes, lvl0, base;
    logic [7:0] seq0;

    vecs[0] = '{8'b1011_0000, 5, 8'h0D, 1};
    vecs[1] = '{8'b1111_1111, 0, 8'hFF, 2};
    vecs[2] = '{8'b0000_0001, 2, 8'h80, 3};
    vecs[3] = '{8'b1000_0000, 1, 8'h01, 4};
    vecs[4] = '{8'b1100_0011, 7, 8'hC3, 5};
    vecs[5] = '{8'b0101_0000, 0, 8'h0A, 6};
    vecs[6] = '{8'b1110_0100, 3, 8'h27, 7};

    i_reset = 1'b0; i_enable = 1'b1; i_bit = 1'b0; i_bit_valid = 1'b0;
    i_ready = 1'b0; i_packet_ongoing = 1'b0;
    bit_mode = 0; ready_mode = 0; force_ongoing = 1'b0;
    pack_en = 1'b0; chk_level = 1'b0;
    prev_write = 1'b0; prev_start = 1'b0; ready_at_edge = 1'b0;
    pkt_count = 0; n_starts = 0; last_seq = '0; last_seq_valid = 1'b0; wrap_seen = 1'b0;
    model_reset();

    // Reset state
    do_reset();
    check("rst_start", 32'(o_start_packet), 32'd0);
    check("rst_write", 32'(o_write), 32'd0);
    check("rst_dat", 32'(o_dat), 32'd0);
    check("rst_level", 32'(o_fifo_level), 32'd0);
    check("rst_ovf", 32'(o_overflow), 32'd0);
    check("rst_seq", 32'(o_seq), 32'd0);
    check("rst_size", 32'(o_packet_size), 32'(PB + 2));

    // Packer table: bit order and enable-low gaps
    for (int r = 0; r < 7; r++) begin
      for (int k = 0; k < 8; k++) begin
        if (k == 3) repeat (vecs[r].gap) feed_bit(1'($urandom_range(0, 1)), 1'b0);
        feed_bit(vecs[r].seq_bits[7-k], 1'b1);
      end
      mq.push_back(vecs[r].exp_byte);
      check("tbl_level", 32'(o_fifo_level), 32'(vecs[r].exp_level));
    end
    pack_en = 1'b1; chk_level = 1'b1;

    // Top up to a full payload; the table bytes must come out first, in order
    ready_mode = 2;
    for (int i = 0; i < 9; i++) feed_byte(8'($urandom));
    wait_pkts(1, 400);

    // 16 bytes of 0x01: seq 0, payload 0x01 x16, checksum 0x00; then seq 1
    do_reset();
    ready_mode = 1;
    base = pkt_count;
    for (int i = 0; i < PB; i++) feed_byte(8'h01);
    wait_pkts(base + 1, 200);
    check("p1_seq_byte", 32'(last_pkt[0]), 32'h00);
    check("p1_first_pl", 32'(last_pkt[1]), 32'h01);
    check("p1_last_pl", 32'(last_pkt[PB]), 32'h01);
    check("p1_csum", 32'(last_pkt[PB+1]), 32'h00);
    check("p1_oseq", 32'(o_seq), 32'h01);
    for (int i = 0; i < PB; i++) feed_byte(8'h01);
    wait_pkts(base + 2, 200);
    check("p2_seq_byte", 32'(last_pkt[0]), 32'h01);
    check("p2_csum", 32'(last_pkt[PB+1]), 32'h01);

    // Stall in payload: no writes and no pops while i_ready is low
    for (int i = 0; i < PB; i++) feed_byte(8'($urandom));
    wait_idx(3, 200);
    ready_mode = 0;
    lvl0 = 32'(o_fifo_level);
    writes = 0;
    repeat (50) begin
      tick();
      if (o_write) writes++;
    end
    check("stall_writes", 32'(writes), 32'd0);
    check("stall_level", 32'(o_fifo_level), 32'(lvl0));
    ready_mode = 1;
    wait_pkts(base + 3, 200);

    // Overflow: fill to DEPTH with packet_com busy, then one more byte
    do_reset();
    force_ongoing = 1'b1; ready_mode = 0;
    for (int i = 0; i < DEPTH; i++) feed_byte(8'($urandom));
    check("full_level", 32'(o_fifo_level), 32'(DEPTH));
    check("full_no_ovf", 32'(o_overflow), 32'd0);
    feed_byte(8'hA5);
    check("ovf_set", 32'(o_overflow), 32'd1);
    check("ovf_level", 32'(o_fifo_level), 32'(DEPTH));
    do_reset();
    check("ovf_cleared", 32'(o_overflow), 32'd0);
    force_ongoing = 1'b0;

    // Reset during payload byte 5 abandons the packet
    ready_mode = 1;
    for (int i = 0; i < PB; i++) feed_byte(8'($urandom));
    wait_idx(6, 200);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check("mid_rst_write", 32'(o_write), 32'd0);
    check("mid_rst_level", 32'(o_fifo_level), 32'd0);
    starts0 = n_starts;
    for (int i = 0; i < PB - 1; i++) feed_byte(8'($urandom));
    repeat (30) tick();
    check("no_early_start", 32'(n_starts), 32'(starts0));
    base = pkt_count;
    feed_byte(8'($urandom));
    wait_pkts(base + 1, 200);

    // 256 random packets: seq wraps through 0xFF -> 0x00
    seq0 = seq_m;
    base = pkt_count;
    bit_mode = 1; ready_mode = 2;
    wait_pkts(base + 256, 80000);
    bit_mode = 0; i_bit_valid = 1'b0;
    check("seq_wrapped", 32'(wrap_seen), 32'd1);
    check("seq_after_256", 32'(o_seq), 32'(seq0));
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
